aes_share_loader: RTL and testbench

- Upstream stage of the masked round-based AES datapath.
- Accepts one 128-bit plaintext and one 128-bit key, each with a fresh 128-bit mask, through a valid/ready handshake.
- Splits each byte into two Boolean shares and streams them, one byte-pair per cycle for 16 consecutive cycles, on the 16-bit pt_share/key_share inputs of the datapath.
- Holds off further blocks until the controller reports completion of the current encryption.

---
 rtl/aes_share_loader_pkg.sv | 26 ++
 rtl/aes_share_loader_share_shifter.sv | 55 +++++
 rtl/aes_share_loader.sv | 138 +++++++++++++
 tb/tb_aes_share_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_share_loader_pkg.sv
// ============================================================================
// aes_share_loader_pkg : shared constants, FSM encoding and share-word layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_share_loader_pkg;

  localparam int AES_NBYTES = 16;
  localparam int SHARE_W    = 8;

  // Share word layout, common to loader and datapath
  localparam int MASKED_HI_MSB = 15;
  localparam int MASKED_HI_LSB = 8;
  localparam int MASK_LO_MSB   = 7;
  localparam int MASK_LO_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/aes_share_loader_share_shifter.sv
// ============================================================================
// aes_share_loader_share_shifter : parallel-load, byte-shift-left share register
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_share_loader_share_shifter
  import aes_share_loader_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES,
  parameter int BW     = SHARE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [NBYTES*BW-1:0] masked_i,
  input  logic [NBYTES*BW-1:0] mask_i,
  output logic [2*BW-1:0]      share_o
);

  localparam int DW = NBYTES * BW;

  logic [DW-1:0] masked_q, masked_d;
  logic [DW-1:0] mask_q, mask_d;

  always_comb begin
    masked_d = masked_q;
    mask_d   = mask_q;
    if (load_i) begin
      masked_d = masked_i;
      mask_d   = mask_i;
    end else if (shift_i) begin
      // Zero fill so the registers are empty once the last byte has left
      masked_d = {masked_q[DW-BW-1:0], {BW{1'b0}}};
      mask_d   = {mask_q[DW-BW-1:0], {BW{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      masked_q <= '0;
      mask_q   <= '0;
    end else begin
      masked_q <= masked_d;
      mask_q   <= mask_d;
    end
  end

  assign share_o[MASKED_HI_MSB:MASKED_HI_LSB] = masked_q[DW-1 -: BW];
  assign share_o[MASK_LO_MSB:MASK_LO_LSB]     = mask_q[DW-1 -: BW];

endmodule

`default_nettype wire

// File: rtl/aes_share_loader.sv
// ============================================================================
// aes_share_loader : masks a pt/key block on capture and streams Boolean share
// byte-pairs into the masked AES datapath, one per cycle. Revision: 1.0
// ============================================================================
`default_nettype none

module aes_share_loader
  import aes_share_loader_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES,
  parameter int BW     = SHARE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBYTES*BW-1:0] pt,
  input  logic [NBYTES*BW-1:0] key,
  input  logic [NBYTES*BW-1:0] mask_pt,
  input  logic [NBYTES*BW-1:0] mask_key,
  input  logic                 core_done,
  output logic [2*BW-1:0]      pt_share,
  output logic [2*BW-1:0]      key_share,
  output logic                 share_valid,
  output logic                 load_start,
  output logic                 load_last
);

  localparam int             CW        = $clog2(NBYTES);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(NBYTES - 1);
  localparam logic [CW-1:0]  CNT_PRE   = CW'(NBYTES - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          share_valid_q, share_valid_d;
  logic          load_start_q, load_start_d;
  logic          load_last_q, load_last_d;
  logic          capture, shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      share_valid_q <= 1'b0;
      load_start_q  <= 1'b0;
      load_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      share_valid_q <= share_valid_d;
      load_start_q  <= load_start_d;
      load_last_q   <= load_last_d;
    end
  end

  // Flag outputs are computed one cycle early so they line up with the byte
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    in_ready_d    = 1'b0;
    share_valid_d = 1'b0;
    load_start_d  = 1'b0;
    load_last_d   = 1'b0;
    capture       = 1'b0;
    shift         = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          capture       = 1'b1;
          cnt_d         = '0;
          state_d       = STREAM;
          share_valid_d = 1'b1;
          load_start_d  = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      STREAM: begin
        shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d         = cnt_q + CW'(1);
          share_valid_d = 1'b1;
          load_last_d   = (cnt_q == CNT_PRE);
        end
      end
      HOLD: begin
        if (core_done) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  aes_share_loader_share_shifter #(
    .NBYTES (NBYTES),
    .BW     (BW)
  ) u_pt_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (capture),
    .shift_i  (shift),
    .masked_i (pt ^ mask_pt),
    .mask_i   (mask_pt),
    .share_o  (pt_share)
  );

  aes_share_loader_share_shifter #(
    .NBYTES (NBYTES),
    .BW     (BW)
  ) u_key_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (capture),
    .shift_i  (shift),
    .masked_i (key ^ mask_key),
    .mask_i   (mask_key),
    .share_o  (key_share)
  );

  assign in_ready    = in_ready_q;
  assign share_valid = share_valid_q;
  assign load_start  = load_start_q;
  assign load_last   = load_last_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_share_loader.sv
// ============================================================================
// tb_aes_share_loader : directed + randomized self-checking bench
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_share_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt, key, mask_pt, mask_key;
  logic         core_done;
  logic [15:0]  pt_share, key_share;
  logic         share_valid, load_start, load_last;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] cap_pt [16];
  logic [15:0] cap_key[16];

  always #5 clk = ~clk;

  aes_share_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pt          (pt),
    .key         (key),
    .mask_pt     (mask_pt),
    .mask_key    (mask_key),
    .core_done   (core_done),
    .pt_share    (pt_share),
    .key_share   (key_share),
    .share_valid (share_valid),
    .load_start  (load_start),
    .load_last   (load_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    return v[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present a block with valid until accepted; returns at the negedge carrying byte 0
  task automatic send(input logic [127:0] p, k, mp, mk);
    int w;
    in_valid = 1'b1; pt = p; key = k; mask_pt = mp; mask_key = mk;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 32'(w < 50), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    pt = rnd128(); key = rnd128(); mask_pt = rnd128(); mask_key = rnd128();
  endtask

  // Expected byte-pair for position i: {value ^ mask, mask}
  task automatic check_stream(input logic [127:0] p, k, mp, mk,
                              input int done_at, input int stop_at);
    for (int i = 0; i < 16; i++) begin
      chk("share_valid", 32'(share_valid), 32'd1);
      chk("pt_share",  32'(pt_share),  32'({byte_of(p, i) ^ byte_of(mp, i), byte_of(mp, i)}));
      chk("key_share", 32'(key_share), 32'({byte_of(k, i) ^ byte_of(mk, i), byte_of(mk, i)}));
      chk("load_start", 32'(load_start), 32'(i == 0));
      chk("load_last",  32'(load_last),  32'(i == 15));
      chk("pt_recon", 32'(pt_share[15:8] ^ pt_share[7:0]), 32'(byte_of(p, i)));
      if (byte_of(mp, i) != 8'h00)
        chk("pt_unmasked_exposed", 32'(pt_share[15:8] == byte_of(p, i)), 32'd0);
      cap_pt[i]  = pt_share;
      cap_key[i] = key_share;
      core_done  = (i == done_at);
      if (i == stop_at) return;
      @(negedge clk);
    end
    core_done = 1'b0;
    chk("post_valid",     32'(share_valid), 32'd0);
    chk("post_pt_share",  32'(pt_share),    32'd0);
    chk("post_key_share", 32'(key_share),   32'd0);
    chk("post_in_ready",  32'(in_ready),    32'd0);
    chk("post_last",      32'(load_last),   32'd0);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] fips_pt, fips_key, a5, p, k, mp, mk, p2;
    int cnt;
    fips_pt  = 128'h00112233445566778899aabbccddeeff;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    a5       = {16{8'hA5}};

    rst = 1'b1; in_valid = 1'b0; core_done = 1'b0;
    pt = '0; key = '0; mask_pt = '0; mask_key = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(share_valid), 32'd0);
    chk("rst_pt",    32'(pt_share),    32'd0);
    chk("rst_key",   32'(key_share),   32'd0);
    chk("rst_start", 32'(load_start),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // FIPS-197 vector with constant masks
    send(fips_pt, fips_key, a5, a5);
    check_stream(fips_pt, fips_key, a5, a5, -1, -1);
    chk("fips_pt0",  32'(cap_pt[0]),   32'h0000A5A5);
    chk("fips_key0", 32'(cap_key[0]),  32'h0000A5A5);
    chk("fips_pt1",  32'(cap_pt[1]),   32'h0000B4A5);
    chk("fips_key1", 32'(cap_key[1]),  32'h0000A4A5);
    chk("fips_pt15", 32'(cap_pt[15]),  32'h00005AA5);
    chk("fips_key15",32'(cap_key[15]), 32'h0000AAA5);
    pulse_done();

    // Zero masks: plaintext appears directly in the high byte
    send(fips_pt, fips_key, '0, '0);
    check_stream(fips_pt, fips_key, '0, '0, -1, -1);
    for (int i = 0; i < 16; i++)
      chk("zero_mask_pt", 32'(cap_pt[i]), 32'({8'((i << 4) | i), 8'h00}));

    // Backpressure: second block held with valid while in HOLD
    p2 = rnd128(); mp = rnd128(); k = rnd128(); mk = rnd128();
    in_valid = 1'b1; pt = p2; key = k; mask_pt = mp; mask_key = mk;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(share_valid), 32'd0);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("bp_ready_after_done", 32'(in_ready), 32'd1);
    chk("bp_no_early_byte", 32'(share_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_stream(p2, k, mp, mk, -1, -1);
    pulse_done();

    // Spurious core_done during byte 7 must not shorten the stream
    p = rnd128(); k = rnd128(); mp = rnd128(); mk = rnd128();
    send(p, k, mp, mk);
    check_stream(p, k, mp, mk, 7, -1);
    repeat (3) @(negedge clk);
    chk("spurious_hold", 32'(in_ready), 32'd0);
    pulse_done();

    // Asynchronous reset in the middle of byte 9
    p = rnd128(); k = rnd128(); mp = rnd128(); mk = rnd128();
    send(p, k, mp, mk);
    check_stream(p, k, mp, mk, -1, 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(share_valid), 32'd0);
    chk("arst_pt",    32'(pt_share),    32'd0);
    chk("arst_key",   32'(key_share),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (share_valid !== 1'b0 || pt_share !== 16'h0) cnt++;
    end
    chk("arst_no_residual", 32'(cnt), 32'd0);

    // Randomized blocks with fresh masks and random completion delay
    for (int b = 0; b < 100; b++) begin
      p = rnd128(); k = rnd128(); mp = rnd128(); mk = rnd128();
      send(p, k, mp, mk);
      check_stream(p, k, mp, mk, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
